match_event_logger: RTL and testbench

- Downstream consumer of the serial 1101 Mealy sequence detector.
- Each clock carries one serial bit. The block numbers those bits and samples the detector's match output `y` at every rising clock edge.
- It records the bit index at which each match completed into a small first-word-fall-through FIFO and keeps a saturating match count.
- A host-side reader drains the FIFO through a simple valid/read handshake.

---
 rtl/match_event_logger_if.sv | 26 ++
 rtl/match_event_logger.sv | 105 ++++++++++
 tb/tb_match_event_logger.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/match_event_logger_if.sv
// Host-facing bundle of the match event logger: detector inputs, soft clear,
// read handshake and status outputs.
interface match_event_logger_if #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic             bit_en;
  logic             y;
  logic             clear;
  logic             rd_en;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_data;
  logic             full;
  logic             overflow;
  logic [CNT_W-1:0] count;

  modport master (
    output bit_en, y, clear, rd_en,
    input  rd_valid, rd_data, full, overflow, count
  );

  modport slave (
    input  bit_en, y, clear, rd_en,
    output rd_valid, rd_data, full, overflow, count
  );
endinterface

// File: rtl/match_event_logger.sv
// Match event logger: numbers serial bits, stores the bit index of each 1101
// detector match in a first-word-fall-through FIFO, keeps a saturating match
// count and a sticky overflow flag.
module match_event_logger #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  match_event_logger_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_nx, rd_ptr_nx;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [IDX_W-1:0] mem_q [DEPTH];

  logic push, pop, wr_en;

  // A push is accepted unless the FIFO is full and nothing leaves this cycle.
  assign push      = bus.bit_en & bus.y;
  assign pop       = bus.rd_en & (state_q != EMPTY);
  assign wr_en     = push & ((state_q != FULL) | pop);
  assign wr_ptr_nx = wr_ptr_q + 1'b1;
  assign rd_ptr_nx = rd_ptr_q + 1'b1;

  // Occupancy next state; the wrap-around pointer compare resolves full/empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = (wr_ptr_nx == rd_ptr_q) ? FULL : PARTIAL;
      end
      PARTIAL: begin
        if (push && !pop)      state_d = (wr_ptr_nx == rd_ptr_q) ? FULL : PARTIAL;
        else if (pop && !push) state_d = (rd_ptr_nx == wr_ptr_q) ? EMPTY : PARTIAL;
      end
      FULL: begin
        if (pop && !push) state_d = PARTIAL;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.clear) state_d = EMPTY;
  end

  // Datapath next state: bit index, pointers, saturating count, sticky overflow.
  always_comb begin
    bit_idx_d  = bus.bit_en ? bit_idx_q + 1'b1 : bit_idx_q;
    wr_ptr_d   = wr_en ? wr_ptr_nx : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_nx : rd_ptr_q;
    count_d    = count_q;
    if (push && (count_q != '1)) count_d = count_q + 1'b1;
    overflow_d = overflow_q | (push & ~wr_en);
    if (bus.clear) begin
      bit_idx_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      bit_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are masked by the empty decode, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_en && !bus.clear && !reset) mem_q[wr_ptr_q] <= bit_idx_q;
  end

  assign bus.rd_valid = (state_q != EMPTY);
  assign bus.full     = (state_q == FULL);
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;
  assign bus.rd_data  = (state_q != EMPTY) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench for match_event_logger: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_match_event_logger;

  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int IDX_MOD = 1 << IDX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  match_event_logger_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  match_event_logger #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int       mq[$];
  int       m_cnt;
  int       m_idx;
  bit       m_ovf;
  bit [3:0] hist;

  typedef struct {
    bit be;
    bit x;
    bit rd;
    bit vld;
    int data;
    int cnt;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rd_valid"}, int'(bus.rd_valid), (mq.size() > 0) ? 1 : 0);
    chk({tag, ".rd_data"},  int'(bus.rd_data),  (mq.size() > 0) ? mq[0] : 0);
    chk({tag, ".full"},     int'(bus.full),     (mq.size() == DEPTH) ? 1 : 0);
    chk({tag, ".overflow"}, int'(bus.overflow), int'(m_ovf));
    chk({tag, ".count"},    int'(bus.count),    m_cnt);
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0;
    m_idx = 0;
    m_ovf = 1'b0;
    hist  = 4'b0000;
  endtask

  task automatic model_step(input bit be, input bit yv, input bit rd, input bit clr);
    bit push, pop;
    if (clr) begin
      model_reset();
    end else begin
      push = be && yv;
      pop  = rd && (mq.size() > 0);
      if (push && m_cnt < CNT_MAX) m_cnt++;
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(m_idx);
        else m_ovf = 1'b1;
      end
      if (be) m_idx = (m_idx + 1) % IDX_MOD;
    end
  endtask

  // Overlapping 1101 detector standing in for the upstream block.
  function automatic bit det(input bit x);
    hist = {hist[2:0], x};
    return (hist == 4'b1101);
  endfunction

  task automatic step(input bit be, input bit yv, input bit rd, input bit clr, input string tag);
    @(negedge clk);
    bus.bit_en = be;
    bus.y      = yv;
    bus.rd_en  = rd;
    bus.clear  = clr;
    model_step(be, yv, rd, clr);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.bit_en = 1'b0;
    bus.y      = 1'b0;
    bus.rd_en  = 1'b0;
    bus.clear  = 1'b0;
    model_reset();
    @(negedge clk);
    chk_model("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit yv;

    // be, x, rd, expected valid, data, count
    tbl[0] = '{1, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 1, 0, 1, 3, 1};
    tbl[4] = '{1, 1, 0, 1, 3, 1};
    tbl[5] = '{1, 0, 0, 1, 3, 1};
    tbl[6] = '{1, 1, 0, 1, 3, 2};
    tbl[7] = '{0, 0, 1, 1, 6, 2};
    tbl[8] = '{0, 0, 1, 0, 0, 2};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      yv = tbl[i].be ? det(tbl[i].x) : 1'b0;
      step(tbl[i].be, yv, tbl[i].rd, 1'b0, "tbl");
      chk("tbl.vld",   int'(bus.rd_valid), int'(tbl[i].vld));
      chk("tbl.data",  int'(bus.rd_data),  tbl[i].data);
      chk("tbl.count", int'(bus.count),    tbl[i].cnt);
    end

    // Five matches with no reads: fifth is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0, "ovf");
      if (i == 3) chk("ovf.full4", int'(bus.full), 1);
    end
    chk("ovf.flag",  int'(bus.overflow), 1);
    chk("ovf.count", int'(bus.count), 5);
    for (int i = 0; i < 4; i++) begin
      chk("ovf.order", int'(bus.rd_data), i);
      step(0, 0, 1, 0, "ovf_pop");
    end
    chk("ovf.sticky", int'(bus.overflow), 1);
    chk("ovf.empty",  int'(bus.rd_valid), 0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, "fpp_fill");
    step(1, 1, 1, 0, "fpp");
    chk("fpp.full",  int'(bus.full), 1);
    chk("fpp.ovf",   int'(bus.overflow), 0);
    chk("fpp.head",  int'(bus.rd_data), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "fpp_pop");
    chk("fpp.tail",  int'(bus.rd_data), 4);

    // Bit index wrap and y ignored without bit_en.
    do_reset();
    for (int i = 0; i < 300; i++) step(1, (i == 259), 0, 0, "wrap");
    chk("wrap.data",  int'(bus.rd_data), 3);
    step(0, 1, 0, 0, "noen");
    chk("noen.count", int'(bus.count), 1);

    // Count saturation with reads keeping the FIFO shallow.
    do_reset();
    for (int i = 0; i < 260; i++) step(1, 1, 1, 0, "sat");
    chk("sat.count", int'(bus.count), CNT_MAX);
    chk("sat.ovf",   int'(bus.overflow), 0);

    // Soft clear concurrent with a match, then bit index restart.
    do_reset();
    step(1, 1, 0, 0, "clr_fill");
    step(1, 1, 0, 0, "clr_fill");
    chk("clr.pre", int'(bus.count), 2);
    step(1, 1, 0, 1, "clr");
    chk("clr.valid", int'(bus.rd_valid), 0);
    chk("clr.count", int'(bus.count), 0);
    step(0, 0, 0, 0, "clr_idle");
    step(1, 1, 0, 0, "clr_idx");
    chk("clr.idx0", int'(bus.rd_data), 0);
    step(1, 1, 0, 0, "clr_idx1");

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("areset.valid", int'(bus.rd_valid), 0);
    chk("areset.count", int'(bus.count), 0);
    chk("areset.data",  int'(bus.rd_data), 0);
    model_reset();
    bus.bit_en = 1'b0;
    bus.y      = 1'b0;
    bus.rd_en  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 0, 0, "areset_idx");
    chk("areset.idx0", int'(bus.rd_data), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
